// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Pipeline register between Instruction Decode and Execute.
//
// The stage captures the decoded operands, immediate, pc, register indices and
// control bits of the instruction in ID. It also detects load-use hazards
// against the instruction currently in EX.
//
// On a hazard the stage inserts a one-cycle bubble into EX. It raises stall_id
// so that PC and IF/ID hold the dependent instruction, and it counts the
// bubble. A branch flush from EX squashes the decode slot without counting.
// A same-cycle write-back is bypassed into the captured operands, because the
// register file read in ID cannot yet see it.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_valid            decode slot holds a real instruction
//   id_pc               pc of the decoded instruction
//   id_rs1, id_rs2      source register indices
//   id_rd               destination register index
//   id_rdata1/2         register-file read data (signed)
//   id_imm              sign-extended immediate (signed)
//   id_ctrl             {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,ALUOp[1:0]}
//   wb_RegWrite         write-back stage writes the register file this cycle
//   wb_rd, wb_data      write-back destination and value
//   ex_flush            branch taken in EX: squash the decode slot
//   stall_id            combinational: hold PC and IF/ID this cycle
//   ex_valid            EX slot holds a real instruction
//   ex_pc, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_ctrl
//                       registered copies of the ID fields (operands bypassed)
//   bubble_count        saturating count of load-use bubbles since reset
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,

   input  logic                   id_valid,
   input  logic [XLEN-1:0]        id_pc,
   input  logic [4:0]             id_rs1,
   input  logic [4:0]             id_rs2,
   input  logic [4:0]             id_rd,
   input  logic signed [XLEN-1:0] id_rdata1,
   input  logic signed [XLEN-1:0] id_rdata2,
   input  logic signed [XLEN-1:0] id_imm,
   input  logic [7:0]             id_ctrl,

   input  logic                   wb_RegWrite,
   input  logic [4:0]             wb_rd,
   input  logic signed [XLEN-1:0] wb_data,

   input  logic                   ex_flush,

   output logic                   stall_id,
   output logic                   ex_valid,
   output logic [XLEN-1:0]        ex_pc,
   output logic [4:0]             ex_rs1,
   output logic [4:0]             ex_rs2,
   output logic [4:0]             ex_rd,
   output logic signed [XLEN-1:0] ex_op1,
   output logic signed [XLEN-1:0] ex_op2,
   output logic signed [XLEN-1:0] ex_imm,
   output logic [7:0]             ex_ctrl,
   output logic [CNT_W-1:0]       bubble_count
);

   // Bit position of MemRead inside the control byte.
   localparam int CTRL_MEM_READ = 6;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic                   hazard;
   logic signed [XLEN-1:0] op1_sel;
   logic signed [XLEN-1:0] op2_sel;

   // ---------------------------------------------------------------------------
   // Load-use hazard detection.
   // A load in EX produces its data only at the end of MEM. A consumer in ID
   // must therefore wait one cycle. It then picks up the loaded value through
   // the forwarding unit. Writes to x0 are never a dependency.
   // ---------------------------------------------------------------------------
   assign hazard = ex_valid
                 & ex_ctrl[CTRL_MEM_READ]
                 & (ex_rd != 5'd0)
                 & id_valid
                 & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   // A flush squashes the dependent instruction anyway, so there is nothing
   // to hold. During reset, IF/ID must be free to move.
   assign stall_id = hazard & ~ex_flush & ~rst;

   // ---------------------------------------------------------------------------
   // Operand select with write-back bypass.
   // The register file is written at the end of this cycle, so its read port
   // still shows the old value. The write-back data is taken directly instead.
   // x0 reads zero regardless of what the file or write-back says.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      //       leave it unassigned and infer a latch.
      op1_sel = id_rdata1;
      op2_sel = id_rdata2;

      if (id_rs1 == 5'd0) begin
         op1_sel = '0;
      end else if (wb_RegWrite && (wb_rd == id_rs1)) begin
         op1_sel = wb_data;
      end

      if (id_rs2 == 5'd0) begin
         op2_sel = '0;
      end else if (wb_RegWrite && (wb_rd == id_rs2)) begin
         op2_sel = wb_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage register. Priority is reset > flush > hazard > capture.
   // On a flush or a bubble, only ex_valid and ex_ctrl are cleared. Clearing
   // ex_ctrl is enough to make the slot harmless downstream (no RegWrite, no
   // MemWrite, no Branch). The data fields simply hold.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      //       flop samples the pre-edge values regardless of statement order.
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_op1       <= '0;
         ex_op2       <= '0;
         ex_imm       <= '0;
         ex_ctrl      <= '0;
         bubble_count <= '0;
      end else if (ex_flush) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
      end else if (hazard) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         if (bubble_count != CNT_MAX) begin
            bubble_count <= bubble_count + 1'b1;
         end
      end else begin
         ex_valid <= id_valid;
         ex_pc    <= id_pc;
         ex_rs1   <= id_rs1;
         ex_rs2   <= id_rs2;
         ex_rd    <= id_rd;
         ex_op1   <= op1_sel;
         ex_op2   <= op2_sel;
         ex_imm   <= id_imm;
         // An empty decode slot must not carry live control into EX.
         ex_ctrl  <= id_valid ? id_ctrl : 8'h00;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Scoreboard bench for id_ex_stage. A driver applies directed and random
// stimulus on the falling edge. It keeps a behavioural model of "what is in
// EX" and pushes the expected stall and the expected post-edge EX contents
// into queues. A separate monitor pops those queues and compares them against
// the DUT. A second instance with CNT_W=2 shares the stimulus, so that
// bubble-counter saturation can be checked.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int XLEN = 64;

   typedef struct {
      bit          rst;
      bit          id_valid;
      logic [63:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] rdata1;
      logic [63:0] rdata2;
      logic [63:0] imm;
      logic [7:0]  ctrl;
      bit          wb_we;
      logic [4:0]  wb_rd;
      logic [63:0] wb_data;
      bit          flush;
   } stim_t;

   typedef struct {
      bit          valid;
      logic [63:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] op1;
      logic [63:0] op2;
      logic [63:0] imm;
      logic [7:0]  ctrl;
      logic [31:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   id_valid = 1'b0;
   logic [XLEN-1:0]        id_pc = '0;
   logic [4:0]             id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic signed [XLEN-1:0] id_rdata1 = '0, id_rdata2 = '0, id_imm = '0;
   logic [7:0]             id_ctrl = '0;
   logic                   wb_RegWrite = 1'b0;
   logic [4:0]             wb_rd = '0;
   logic signed [XLEN-1:0] wb_data = '0;
   logic                   ex_flush = 1'b0;

   logic                   stall_id, ex_valid;
   logic [XLEN-1:0]        ex_pc;
   logic [4:0]             ex_rs1, ex_rs2, ex_rd;
   logic signed [XLEN-1:0] ex_op1, ex_op2, ex_imm;
   logic [7:0]             ex_ctrl;
   logic [31:0]            bubble_count;

   logic                   s_stall_id, s_ex_valid;
   logic [XLEN-1:0]        s_ex_pc;
   logic [4:0]             s_ex_rs1, s_ex_rs2, s_ex_rd;
   logic signed [XLEN-1:0] s_ex_op1, s_ex_op2, s_ex_imm;
   logic [7:0]             s_ex_ctrl;
   logic [1:0]             s_bubble_count;

   int total = 0;
   int bad   = 0;

   bit   exp_stall_q[$];
   exp_t exp_q[$];
   exp_t m;          // model: current EX contents and counters

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .id_imm(id_imm), .id_ctrl(id_ctrl),
      .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_flush(ex_flush),
      .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
      .ex_ctrl(ex_ctrl), .bubble_count(bubble_count)
   );

   id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .id_imm(id_imm), .id_ctrl(id_ctrl),
      .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_flush(ex_flush),
      .stall_id(s_stall_id), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
      .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
      .ex_op1(s_ex_op1), .ex_op2(s_ex_op2), .ex_imm(s_ex_imm),
      .ex_ctrl(s_ex_ctrl), .bubble_count(s_bubble_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Value the EX stage should see for one source register.
   function automatic logic [63:0] operand(input logic [4:0] rs, input logic [63:0] rf, input stim_t s);
      if (rs == 5'd0) return 64'd0;
      if (s.wb_we && s.wb_rd == rs) return s.wb_data;
      return rf;
   endfunction

   // One clock of stimulus. Returns whether the model says ID must hold.
   task automatic drive(input stim_t s, output bit stall);
      bit load_in_ex, dep;
      @(negedge clk);
      rst = s.rst; id_valid = s.id_valid; id_pc = s.pc;
      id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
      id_rdata1 = s.rdata1; id_rdata2 = s.rdata2; id_imm = s.imm; id_ctrl = s.ctrl;
      wb_RegWrite = s.wb_we; wb_rd = s.wb_rd; wb_data = s.wb_data; ex_flush = s.flush;

      // A real load (MemRead) writing a non-zero register sits in EX,
      // and the real instruction in ID reads that register.
      load_in_ex = m.valid && m.ctrl[6] && m.rd != 5'd0;
      dep        = s.id_valid && (m.rd == s.rs1 || m.rd == s.rs2);
      stall      = load_in_ex && dep && !s.flush && !s.rst;
      exp_stall_q.push_back(stall);

      if (s.rst) begin
         m = '{valid: 1'b0, pc: '0, rs1: '0, rs2: '0, rd: '0, op1: '0, op2: '0,
               imm: '0, ctrl: '0, cnt: '0, cnt2: '0};
      end else if (s.flush) begin
         m.valid = 1'b0;
         m.ctrl  = 8'h00;
      end else if (load_in_ex && dep) begin
         m.valid = 1'b0;
         m.ctrl  = 8'h00;
         if (m.cnt  != 32'hFFFF_FFFF) m.cnt  = m.cnt + 1;
         if (m.cnt2 != 2'd3)          m.cnt2 = m.cnt2 + 1;
      end else begin
         m.valid = s.id_valid;
         m.pc    = s.pc;
         m.rs1   = s.rs1;
         m.rs2   = s.rs2;
         m.rd    = s.rd;
         m.op1   = operand(s.rs1, s.rdata1, s);
         m.op2   = operand(s.rs2, s.rdata2, s);
         m.imm   = s.imm;
         m.ctrl  = s.id_valid ? s.ctrl : 8'h00;
      end
      exp_q.push_back(m);
   endtask

   // Issue an instruction, holding it in ID for as long as the model stalls.
   task automatic issue(input stim_t s);
      bit st;
      int n = 0;
      do begin
         drive(s, st);
         n++;
      end while (st && n < 4);
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{rst: 0, id_valid: 0, pc: '0, rs1: '0, rs2: '0, rd: '0, rdata1: '0,
            rdata2: '0, imm: '0, ctrl: '0, wb_we: 0, wb_rd: '0, wb_data: '0, flush: 0};
      return s;
   endfunction

   function automatic stim_t load(input logic [4:0] rd);
      stim_t s = idle();
      s.id_valid = 1; s.rd = rd; s.ctrl = 8'hD0; s.pc = 64'h1000;
      return s;
   endfunction

   function automatic stim_t user(input logic [4:0] rs1, input logic [4:0] rs2);
      stim_t s = idle();
      s.id_valid = 1; s.rs1 = rs1; s.rs2 = rs2; s.rd = 5'd9; s.ctrl = 8'h82;
      s.pc = 64'h2000; s.rdata1 = 64'h1111; s.rdata2 = 64'h2222; s.imm = 64'h40;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst      = ($urandom_range(0, 59) == 0);
      s.id_valid = ($urandom_range(0, 99) < 85);
      s.pc       = {$urandom, $urandom};
      s.rs1      = 5'($urandom_range(0, 7));
      s.rs2      = 5'($urandom_range(0, 7));
      s.rd       = 5'($urandom_range(0, 7));
      s.rdata1   = {$urandom, $urandom};
      s.rdata2   = {$urandom, $urandom};
      s.imm      = {$urandom, $urandom};
      s.ctrl     = 8'($urandom);
      s.ctrl[6]  = ($urandom_range(0, 9) < 4);
      s.wb_we    = $urandom_range(0, 1);
      s.wb_rd    = 5'($urandom_range(0, 7));
      s.wb_data  = {$urandom, $urandom};
      s.flush    = ($urandom_range(0, 7) == 0);
      return s;
   endfunction

   // Monitor: stall_id is checked once the falling-edge inputs have settled,
   // and the registered outputs just after the rising edge.
   initial begin
      bit   es;
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_stall_q.size() != 0) begin
            es = exp_stall_q.pop_front();
            check("stall_id", 64'(stall_id), 64'(es));
         end
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("ex_valid",       64'(ex_valid),       64'(e.valid));
            check("ex_ctrl",        64'(ex_ctrl),        64'(e.ctrl));
            check("bubble_count",   64'(bubble_count),   64'(e.cnt));
            check("bubble_count_2", 64'(s_bubble_count), 64'(e.cnt2));
            // The data fields only matter for a live slot, or for the
            // all-zero state that reset leaves behind.
            if (e.valid || e.pc == 0) begin
               check("ex_pc",  ex_pc,          e.pc);
               check("ex_rs1", 64'(ex_rs1),    64'(e.rs1));
               check("ex_rs2", 64'(ex_rs2),    64'(e.rs2));
               check("ex_rd",  64'(ex_rd),     64'(e.rd));
               check("ex_op1", ex_op1,         e.op1);
               check("ex_op2", ex_op2,         e.op2);
               check("ex_imm", ex_imm,         e.imm);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver
   initial begin
      stim_t s;
      bit    st;
      m = '{valid: 1'b0, pc: '0, rs1: '0, rs2: '0, rd: '0, op1: '0, op2: '0,
            imm: '0, ctrl: '0, cnt: '0, cnt2: '0};

      // Reset held for two cycles with every input driven non-zero.
      s = '{rst: 1, id_valid: 1, pc: 64'hDEAD, rs1: 5'd5, rs2: 5'd6, rd: 5'd7,
            rdata1: 64'h11, rdata2: 64'h22, imm: 64'h33, ctrl: 8'hFF, wb_we: 1,
            wb_rd: 5'd5, wb_data: 64'h44, flush: 1};
      drive(s, st);
      drive(s, st);

      // Plain capture of a negative operand.
      s = idle();
      s.id_valid = 1; s.rs1 = 5'd3; s.rs2 = 5'd4; s.rd = 5'd8; s.pc = 64'h100;
      s.rdata1 = -64'sd5; s.rdata2 = 64'h77; s.imm = 64'd16; s.ctrl = 8'h82;
      issue(s);

      // Load-use on rs2: one bubble, then the held instruction is captured.
      issue(load(5'd5));
      issue(user(5'd0, 5'd5));

      // Write-back bypass, and the x0 case with the same stimulus.
      s = idle();
      s.id_valid = 1; s.rs1 = 5'd7; s.rdata1 = 64'd0; s.ctrl = 8'h80;
      s.wb_we = 1; s.wb_rd = 5'd7; s.wb_data = 64'h1234;
      issue(s);
      s.rs1 = 5'd0; s.wb_rd = 5'd0;
      issue(s);

      // A flush wins over a simultaneous hazard.
      issue(load(5'd5));
      s = user(5'd5, 5'd0);
      s.flush = 1;
      issue(s);

      // Reset asserted while a stall is pending, then the instruction retries.
      issue(load(5'd6));
      s = user(5'd6, 5'd6);
      s.rst = 1;
      issue(s);
      issue(user(5'd6, 5'd6));

      // Saturation of the 2-bit counter: five load-use bubbles from zero.
      s = idle();
      s.rst = 1;
      issue(s);
      for (int i = 0; i < 5; i++) begin
         issue(load(5'(i + 1)));
         issue(user(5'(i + 1), 5'd0));
      end
      issue(idle());

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         issue(rand_stim());
      end
      issue(idle());

      repeat (3) @(posedge clk);
      #3;
      check("queue_drain", 64'(exp_q.size() + exp_stall_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
